syscall_queue: RTL and testbench
================================

// Module: syscall_queue
// PURPOSE
//  Wishbone-slave syscall generator with a DEPTH-entry FIFO of pending syscalls.
//  A CPU write to address A with data D enqueues syscall {num=A, info=D}. The system
//  controller consumes entries from the show-ahead head via SYSCALL_pop.
//  Wishbone reads return queue status. Sits on the peripheral bus beside SYSCTRL.
// PARAMETERS
//  ADDR_W  8  syscall number width (= WB_ADRi width)
//  DATA_W  8  syscall info / WB data width
//  DEPTH   4  queue entries; power of 2, >=2; CNT_W=$clog2(DEPTH)+1 must be <= DATA_W-3
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  rst           in   1       asynchronous reset, active-high
//  SYSCALL_clr   in   1       synchronous flush: empties queue, clears overflow flag
//  SYSCALL_pop   in   1       consume head entry (ignored when empty)
//  SYSCALL_trig  out  1       high while queue non-empty
//  SYSCALL_num   out  ADDR_W  head entry number; 0 when empty
//  SYSCALL_info  out  DATA_W  head entry info; 0 when empty
//  SYSCALL_cnt   out  CNT_W   current entry count, 0..DEPTH
//  SYSCALL_ovf   out  1       sticky: a push was dropped because the queue was full
//  WB_ADRi       in   ADDR_W  bus address = syscall number on writes
//  WB_DATi       in   DATA_W  bus write data = syscall info
//  WB_DATo       out  DATA_W  status read data
//  WB_WEi        in   1       write enable
//  WB_CYCi       in   1       bus cycle
//  WB_STBi       in   1       strobe
//  WB_ACKo       out  1       registered acknowledge
// BEHAVIOUR
//  Reset (rst=1, asynchronous): count=0, rd/wr ptr=0, ovf=0, WB_ACKo=0, so
//   SYSCALL_trig=0, SYSCALL_num/info=0, SYSCALL_cnt=0, WB_DATo=0. Storage is not reset.
//  Bus handshake: req = WB_CYCi & WB_STBi & ~WB_ACKo. WB_ACKo <= req, giving one ACK
//   cycle the clock after the strobe and deasserting the next cycle (1 wait state).
//   Back-to-back strobes therefore ack every other cycle.
//  Push: occurs at the edge where req & WB_WEi, so exactly one push per transaction.
//   Writes mem[wr_ptr]={WB_ADRi,WB_DATi}, wr_ptr+1 mod DEPTH, count+1.
//  Pop: occurs at the edge where SYSCALL_pop & count!=0. rd_ptr+1 mod DEPTH, count-1.
//  Head outputs are combinational from mem[rd_ptr] gated by count!=0. Zero latency:
//   an entry pushed at edge N is visible after edge N.
//  Full (count==DEPTH) with push and no pop: entry dropped, ovf<=1, ACK still issued.
//  Full with push and pop at the same edge: both take effect, count stays DEPTH,
//   ovf unchanged.
//  Empty with push and pop at the same edge: pop ignored, push taken, count=1.
//  Priority: rst > SYSCALL_clr > push/pop. A clr at the same edge as a push/pop
//   empties the queue and drops that push; ACK is still generated. ovf clears only
//   via clr or rst.
//  Status read: while WB_ACKo & ~WB_WEi, WB_DATo = {ovf, full, empty, zero pad,
//   count}, with ovf at bit DATA_W-1, full at DATA_W-2, empty at DATA_W-3, and
//   count in bits [CNT_W-1:0]. At all other times WB_DATo=0. WB_ADRi is ignored
//   on reads.
//  Pointers wrap modulo DEPTH. Count is CNT_W wide, so DEPTH is representable.
// TESTING
//  1 Reset, then write adr=0x12 dat=0x34: ACK 1 cycle later, trig=1, num=0x12,
//    info=0x34, cnt=1. Pop: trig=0, num=info=0.
//  2 Push 0x01..0x04 (DEPTH=4), then 5th write 0x05: ACK high, cnt=4, ovf=1.
//    Pops return 0x01,0x02,0x03,0x04 in order; then empty.
//  3 Queue full: push 0x09 at the same edge as a pop. Head advances, cnt=4, ovf=0,
//    and 0x09 is the last entry out.
//  4 Empty queue: push and pop together. cnt=1 and the head is the pushed entry.
//    Pop on empty with no push: no change.
//  5 Three entries plus ovf=1. Read status: WB_DATo=8'b100_00011. Assert SYSCALL_clr
//    coincident with a push: cnt=0, ovf=0, trig=0. Read status: 8'b001_00000.
//  6 Assert rst asynchronously mid-transaction with STB held and 2 entries queued:
//    outputs go to 0 immediately without waiting for clk. After release, the held
//    STB gets a fresh ACK one cycle later and a single push.

Source files
------------

// File: rtl/syscall_queue.sv
// syscall_queue: Wishbone-slave syscall generator. Each bus write enqueues
// {num=address, info=data} into a small FIFO; the system controller drains
// entries from the show-ahead head with SYSCALL_pop. Bus reads return status.
module syscall_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SYSCALL_clr,
  input  logic                   SYSCALL_pop,
  output logic                   SYSCALL_trig,
  output logic [ADDR_W-1:0]      SYSCALL_num,
  output logic [DATA_W-1:0]      SYSCALL_info,
  output logic [$clog2(DEPTH):0] SYSCALL_cnt,
  output logic                   SYSCALL_ovf,
  input  logic [ADDR_W-1:0]      WB_ADRi,
  input  logic [DATA_W-1:0]      WB_DATi,
  output logic [DATA_W-1:0]      WB_DATo,
  input  logic                   WB_WEi,
  input  logic                   WB_CYCi,
  input  logic                   WB_STBi,
  output logic                   WB_ACKo
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;

  logic req, push_req, empty, full, do_push, do_pop;

  // A request is only accepted when ACK is low, so every transaction gets
  // exactly one ACK cycle and at most one push.
  assign req      = WB_CYCi & WB_STBi & ~ack_q;
  assign push_req = req & WB_WEi;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  // clr wins over both push and pop; a full queue still accepts a push when
  // a pop frees the head slot at the same edge.
  assign do_pop   = SYSCALL_pop & ~empty & ~SYSCALL_clr;
  assign do_push  = push_req & (~full | do_pop) & ~SYSCALL_clr;

  // Next-state for pointers, count, sticky overflow and bus acknowledge.
  always_comb begin
    ack_d    = req;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (SYSCALL_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_req & full & ~do_pop) ovf_d = 1'b1;
      if (do_push & ~do_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (do_pop & ~do_push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {WB_ADRi, WB_DATi};
  end

  // Show-ahead head, forced to zero while the queue is empty.
  always_comb begin
    SYSCALL_num  = '0;
    SYSCALL_info = '0;
    if (!empty) {SYSCALL_num, SYSCALL_info} = mem_q[rd_ptr_q];
  end

  // Status word driven only during the ACK cycle of a read.
  always_comb begin
    WB_DATo = '0;
    if (ack_q & ~WB_WEi) begin
      WB_DATo[DATA_W-1]  = ovf_q;
      WB_DATo[DATA_W-2]  = full;
      WB_DATo[DATA_W-3]  = empty;
      WB_DATo[CNT_W-1:0] = cnt_q;
    end
  end

  assign SYSCALL_trig = ~empty;
  assign SYSCALL_cnt  = cnt_q;
  assign SYSCALL_ovf  = ovf_q;
  assign WB_ACKo      = ack_q;

endmodule

// File: tb/tb_syscall_queue.sv
// Directed bench for syscall_queue (ADDR_W=8, DATA_W=8, DEPTH=4).
module tb_syscall_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       sys_clr, sys_pop;
  logic       trig, ovf, ack, we, cyc, stb;
  logic [7:0] num, info, adr, dat_i, dat_o;
  logic [2:0] cnt;

  int n_chk  = 0;
  int n_pass = 0;

  syscall_queue #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .SYSCALL_clr(sys_clr), .SYSCALL_pop(sys_pop),
    .SYSCALL_trig(trig), .SYSCALL_num(num), .SYSCALL_info(info),
    .SYSCALL_cnt(cnt), .SYSCALL_ovf(ovf),
    .WB_ADRi(adr), .WB_DATi(dat_i), .WB_DATo(dat_o),
    .WB_WEi(we), .WB_CYCi(cyc), .WB_STBi(stb), .WB_ACKo(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One bus write; optional pop/clr asserted at the same edge as the push.
  task automatic wb_write(input logic [7:0] a, input logic [7:0] d,
                          input logic pop, input logic clr);
    adr = a; dat_i = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    sys_pop = pop; sys_clr = clr;
    tick;
    chk("wr_ack", 16'(ack), 16'd1);
    chk("wr_dato", 16'(dat_o), 16'h00);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sys_pop = 1'b0; sys_clr = 1'b0;
    tick;
    chk("wr_ack_low", 16'(ack), 16'd0);
  endtask

  task automatic wb_read(output logic [7:0] st);
    we = 1'b0; cyc = 1'b1; stb = 1'b1;
    tick;
    st = dat_o;
    cyc = 1'b0; stb = 1'b0;
    tick;
  endtask

  task automatic do_pop;
    sys_pop = 1'b1;
    tick;
    sys_pop = 1'b0;
  endtask

  task automatic do_clr;
    sys_clr = 1'b1;
    tick;
    sys_clr = 1'b0;
  endtask

  logic [7:0] st;

  initial begin
    rst = 1'b0; sys_clr = 1'b0; sys_pop = 1'b0;
    adr = '0; dat_i = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    #1 rst = 1'b1;
    tick; tick;
    chk("rst_trig", 16'(trig), 16'd0);
    chk("rst_cnt", 16'(cnt), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    chk("rst_ack", 16'(ack), 16'd0);
    chk("rst_num", 16'(num), 16'h00);
    chk("rst_dato", 16'(dat_o), 16'h00);
    rst = 1'b0;
    tick;

    // 1: single write then pop
    wb_write(8'h12, 8'h34, 1'b0, 1'b0);
    chk("t1_trig", 16'(trig), 16'd1);
    chk("t1_num", 16'(num), 16'h12);
    chk("t1_info", 16'(info), 16'h34);
    chk("t1_cnt", 16'(cnt), 16'd1);
    do_pop;
    chk("t1_trig_pop", 16'(trig), 16'd0);
    chk("t1_num_pop", 16'(num), 16'h00);
    chk("t1_info_pop", 16'(info), 16'h00);

    // 2: fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) wb_write(8'(i), 8'(8'h10 + i), 1'b0, 1'b0);
    chk("t2_cnt_full", 16'(cnt), 16'd4);
    chk("t2_ovf_pre", 16'(ovf), 16'd0);
    wb_write(8'h05, 8'h15, 1'b0, 1'b0);
    chk("t2_cnt_ovf", 16'(cnt), 16'd4);
    chk("t2_ovf", 16'(ovf), 16'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_num", 16'(num), 16'(i));
      chk("t2_info", 16'(info), 16'(8'h10 + i));
      do_pop;
    end
    chk("t2_empty_trig", 16'(trig), 16'd0);
    chk("t2_empty_cnt", 16'(cnt), 16'd0);
    chk("t2_ovf_sticky", 16'(ovf), 16'd1);
    do_clr;
    chk("t2_ovf_clr", 16'(ovf), 16'd0);

    // 3: push and pop together while full
    for (int i = 5; i <= 8; i++) wb_write(8'(i), 8'(8'h20 + i), 1'b0, 1'b0);
    chk("t3_cnt_full", 16'(cnt), 16'd4);
    wb_write(8'h09, 8'h29, 1'b1, 1'b0);
    chk("t3_cnt", 16'(cnt), 16'd4);
    chk("t3_ovf", 16'(ovf), 16'd0);
    chk("t3_head", 16'(num), 16'h06);
    for (int i = 6; i <= 9; i++) begin
      chk("t3_num", 16'(num), 16'(i));
      chk("t3_info", 16'(info), 16'(8'h20 + i));
      do_pop;
    end
    chk("t3_empty", 16'(trig), 16'd0);

    // 4: push and pop together while empty, then pop on empty
    wb_write(8'h0A, 8'h3A, 1'b1, 1'b0);
    chk("t4_cnt", 16'(cnt), 16'd1);
    chk("t4_num", 16'(num), 16'h0A);
    chk("t4_info", 16'(info), 16'h3A);
    do_pop;
    chk("t4_cnt_pop", 16'(cnt), 16'd0);
    do_pop;
    chk("t4_cnt_empty_pop", 16'(cnt), 16'd0);
    chk("t4_trig_empty_pop", 16'(trig), 16'd0);
    wb_write(8'h0B, 8'h3B, 1'b0, 1'b0);
    chk("t4_cnt_after", 16'(cnt), 16'd1);
    chk("t4_num_after", 16'(num), 16'h0B);
    do_pop;

    // 5: status reads and clr racing a push
    for (int i = 1; i <= 5; i++) wb_write(8'(8'h20 + i), 8'(8'h40 + i), 1'b0, 1'b0);
    do_pop;
    chk("t5_cnt", 16'(cnt), 16'd3);
    chk("t5_idle_dato", 16'(dat_o), 16'h00);
    wb_read(st);
    chk("t5_status_a", 16'(st), 16'h83);
    wb_write(8'h2F, 8'h4F, 1'b0, 1'b1);
    chk("t5_cnt_clr", 16'(cnt), 16'd0);
    chk("t5_ovf_clr", 16'(ovf), 16'd0);
    chk("t5_trig_clr", 16'(trig), 16'd0);
    wb_read(st);
    chk("t5_status_b", 16'(st), 16'h20);

    // 6: asynchronous reset mid-transaction
    wb_write(8'h31, 8'h51, 1'b0, 1'b0);
    wb_write(8'h32, 8'h52, 1'b0, 1'b0);
    chk("t6_cnt_pre", 16'(cnt), 16'd2);
    adr = 8'h33; dat_i = 8'h53; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cnt", 16'(cnt), 16'd0);
    chk("t6_async_trig", 16'(trig), 16'd0);
    chk("t6_async_num", 16'(num), 16'h00);
    chk("t6_async_ack", 16'(ack), 16'd0);
    tick;
    chk("t6_rst_hold_ack", 16'(ack), 16'd0);
    rst = 1'b0;
    tick;
    chk("t6_ack", 16'(ack), 16'd1);
    chk("t6_cnt", 16'(cnt), 16'd1);
    chk("t6_num", 16'(num), 16'h33);
    chk("t6_info", 16'(info), 16'h53);
    tick;
    chk("t6_ack_low", 16'(ack), 16'd0);
    chk("t6_single_push", 16'(cnt), 16'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
